pwm_mixer: RTL and testbench
============================

PWM_MIXER -- requirements
Module: pwm_mixer

Interface
REQ-001 Parameter CHANNELS, default 4: number of sample channels; power of two, 1..8.
REQ-002 Parameter SAMPLE_W, default 4: bits per unsigned channel sample.
REQ-003 Parameter PRESC_DIV, default 32: clocks per modulator tick; must be at least 1.
REQ-004 Derived constant OUT_W = SAMPLE_W + log2(CHANNELS): mixed level width (6 at defaults).
REQ-005 clock  in  1  system clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 ena  in  1  when low, prescaler, modulator and all state freeze; outputs hold.
REQ-008 samples  in  CHANNELS*SAMPLE_W  packed channel samples, channel 0 in the LSBs, unsigned.
REQ-009 mute  in  CHANNELS  per-channel mute; a set bit contributes 0 to the mix.
REQ-010 mode  in  1  0 = PWM, 1 = first-order sigma-delta.
REQ-011 level  out  OUT_W  currently latched mixed level.
REQ-012 sample_strobe  out  1  one-clock pulse when a new level is latched; upstream updates samples on it.
REQ-013 pwm  out  1  registered modulator output.

Function
REQ-014 Prescaler counts 0..PRESC_DIV-1 while ena=1; a tick occurs on the clock where it equals PRESC_DIV-1, and it wraps to 0 on that clock.
REQ-015 Period counter (OUT_W bits) increments on every tick and wraps 2^OUT_W-1 -> 0.
REQ-016 Period boundary = tick with period counter at 2^OUT_W-1.
REQ-017 At a boundary: level <= sum of unmasked samples (zero-extended to OUT_W, no overflow possible); active mode <= mode; sample_strobe=1 for that one clock.
REQ-018 mode changes between boundaries take effect only at the next boundary; level never changes mid-period.
REQ-019 PWM mode: on each tick, pwm <= 1 iff next period counter value < level; level=0 gives constant 0, and the maximum level gives high for level ticks out of 2^OUT_W.
REQ-020 Sigma-delta mode: accumulator is OUT_W+1 bits; on each tick acc <= {0, acc[OUT_W-1:0]} + level and pwm <= the new acc[OUT_W].
REQ-021 Sigma-delta mode: ones density over 2^OUT_W ticks equals level exactly.
REQ-022 Accumulator clears to 0 on any mode switch taking effect at a boundary.
REQ-023 pwm changes only on tick clocks.
REQ-024 All outputs are registered; there are no combinational input-to-output paths.
REQ-025 ena deasserted on a tick clock suppresses that tick entirely; no strobe is lost, only delayed.

Reset
REQ-026 Reset asserted: prescaler, period counter, accumulator and level all 0; active mode 0 (PWM); pwm=0; sample_strobe=0.
REQ-027 Reset asserted mid-period aborts the period immediately; the first boundary after release occurs 2^OUT_W ticks later.
REQ-028 After reset release, the first tick occurs PRESC_DIV clocks after the first enabled clock.

Verification
REQ-029 Defaults, samples=all channels 15, mute=0, mode=0: after first strobe level=60; pwm high 60 of every 64 ticks; strobe every 2048 clocks.
REQ-030 Defaults, channel 2 = 9, others 0, mute=4'b0100: level=0 and pwm constantly 0 in the following period.
REQ-031 Defaults, mode=1, level=16: pwm high exactly 16 of each 64 ticks, pattern 1 in every 4 ticks; switching mode to 0 mid-period changes nothing until the boundary.
REQ-032 ena held low for 100 clocks mid-period: level, pwm and counters unchanged; strobe is delayed by exactly 100 clocks.
REQ-033 Reset pulsed at period counter 30: all outputs 0 immediately; next strobe 64 ticks after release.
REQ-034 CHANNELS=8, SAMPLE_W=8, PRESC_DIV=1, all samples 255: level=2040 (OUT_W=11); no overflow; pwm high 2040 of 2048 ticks.

Source files
------------

// File: rtl/pwm_mixer_if.sv
// Bus between a sample source and the PWM mixer: enable, channel samples and
// mode in; latched level, sample strobe and modulator output back.
interface pwm_mixer_if #(
    parameter int CHANNELS = 4,
    parameter int SAMPLE_W = 4
);
    localparam int OUT_W = SAMPLE_W + $clog2(CHANNELS);

    logic                         ena;
    logic [CHANNELS*SAMPLE_W-1:0] samples;
    logic [CHANNELS-1:0]          mute;
    logic                         mode;
    logic [OUT_W-1:0]             level;
    logic                         sample_strobe;
    logic                         pwm;

    modport master (output ena, samples, mute, mode, input level, sample_strobe, pwm);
    modport slave  (input ena, samples, mute, mode, output level, sample_strobe, pwm);
endinterface

// File: rtl/pwm_mixer.sv
// Multi-channel sample mixer feeding a PWM / first-order sigma-delta modulator.
// A new mix is latched once per modulator period of 2^OUT_W prescaled ticks.
module pwm_mixer #(
    parameter int CHANNELS  = 4,
    parameter int SAMPLE_W  = 4,
    parameter int PRESC_DIV = 32
) (
    input  logic        clock,
    input  logic        reset,
    pwm_mixer_if.slave  bus
);
    localparam int OUT_W = SAMPLE_W + $clog2(CHANNELS);
    localparam int PW    = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0]    presc;
    logic [OUT_W-1:0] period, period_next;
    logic [OUT_W-1:0] level_q, level_next, mix;
    logic [OUT_W-1:0] acc, acc_base;
    logic [OUT_W:0]   acc_sum;
    logic             act_mode, mode_next;
    logic             tick, boundary;

    always_comb begin
        mix = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (!bus.mute[c])
                mix = mix + OUT_W'(bus.samples[c*SAMPLE_W +: SAMPLE_W]);
    end

    assign tick        = bus.ena && (presc == PRESC_LAST);
    assign boundary    = tick && (&period);
    assign period_next = period + OUT_W'(1);

    // The boundary tick already modulates with the freshly latched level and
    // mode, so the new period starts cleanly from its first tick.
    assign level_next  = boundary ? mix : level_q;
    assign mode_next   = boundary ? bus.mode : act_mode;
    assign acc_base    = (boundary && (bus.mode != act_mode)) ? '0 : acc;
    assign acc_sum     = {1'b0, acc_base} + {1'b0, level_next};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc             <= '0;
            period            <= '0;
            level_q           <= '0;
            acc               <= '0;
            act_mode          <= 1'b0;
            bus.pwm           <= 1'b0;
            bus.sample_strobe <= 1'b0;
        end else begin
            bus.sample_strobe <= boundary;
            if (bus.ena)
                presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                period   <= period_next;
                level_q  <= level_next;
                act_mode <= mode_next;
                if (mode_next) begin
                    // Carry out of the accumulator is the sigma-delta bit.
                    acc     <= acc_sum[OUT_W-1:0];
                    bus.pwm <= acc_sum[OUT_W];
                end else begin
                    acc     <= '0;
                    bus.pwm <= (period_next < level_next);
                end
            end
        end
    end

    assign bus.level = level_q;
endmodule

// File: tb/tb_pwm_mixer.sv
// Randomised and directed bench for pwm_mixer against a tick-indexed model,
// plus a wide 8x8-bit instance checked for saturation-free mixing.
module tb_pwm_mixer;
    localparam int CH = 4, SW = 4, PD = 32, NPER = 64;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pwm_mixer_if #(.CHANNELS(CH), .SAMPLE_W(SW)) bus ();
    pwm_mixer #(.CHANNELS(CH), .SAMPLE_W(SW), .PRESC_DIV(PD)) dut (
        .clock(clock), .reset(reset), .bus(bus));

    pwm_mixer_if #(.CHANNELS(8), .SAMPLE_W(8)) bus8 ();
    pwm_mixer #(.CHANNELS(8), .SAMPLE_W(8), .PRESC_DIV(1)) dut8 (
        .clock(clock), .reset(reset), .bus(bus8));

    int total = 0, bad = 0;

    // Model state: ticks are counted from enabled clocks since reset.
    int en_clks, m_level, m_mode, m_acc, m_pwm, m_strobe;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int mix_sum();
        int s = 0;
        for (int c = 0; c < CH; c++)
            if (!bus.mute[c]) s += int'(bus.samples[c*SW +: SW]);
        return s;
    endfunction

    task automatic model_reset();
        en_clks = 0; m_level = 0; m_mode = 0; m_acc = 0; m_pwm = 0; m_strobe = 0;
    endtask

    task automatic model_step();
        int t, pos;
        m_strobe = 0;
        if (reset) begin model_reset(); return; end
        if (!bus.ena) return;
        en_clks++;
        if (en_clks % PD != 0) return;
        t   = en_clks / PD;
        pos = t % NPER;
        if (pos == 0) begin
            m_level = mix_sum();
            if (int'(bus.mode) != m_mode) m_acc = 0;
            m_mode   = int'(bus.mode);
            m_strobe = 1;
        end
        if (m_mode == 0) begin
            m_pwm = (pos < m_level) ? 1 : 0;
            m_acc = 0;
        end else begin
            m_acc += m_level;
            m_pwm = (m_acc >= NPER) ? 1 : 0;
            m_acc = m_acc % NPER;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check("level", bus.level, m_level);
        check("strobe", bus.sample_strobe, m_strobe);
        check("pwm", bus.pwm, m_pwm);
    endtask

    task automatic run_to_strobe(input int limit, output int n);
        n = 0;
        do begin cycle(); n++; end while (!bus.sample_strobe && n < limit);
        if (!bus.sample_strobe) check("strobe_timeout", n, -1);
    endtask

    // From a strobe sample to the next strobe: counts pwm-high clocks and
    // records one pwm sample per tick.
    task automatic run_period(input int flip_at, input int ena_at,
                              output int ones, output int ones8, output int n,
                              output logic [63:0] tk);
        int sv_pwm, sv_lvl;
        ones = int'(bus.pwm); ones8 = int'(bus8.pwm); n = 0; tk = '0;
        tk[0] = bus.pwm;
        forever begin
            cycle(); n++;
            if (bus.sample_strobe || n >= 4000) break;
            ones  += int'(bus.pwm);
            ones8 += int'(bus8.pwm);
            if (n % PD == 0 && n / PD < 64) tk[n / PD] = bus.pwm;
            if (n == flip_at) bus.mode = 1'b0;
            if (n == ena_at) begin
                sv_pwm = int'(bus.pwm); sv_lvl = int'(bus.level);
                bus.ena = 1'b0;
                repeat (100) begin cycle(); n++; end
                check("ena_hold_pwm", bus.pwm, sv_pwm);
                check("ena_hold_level", bus.level, sv_lvl);
                bus.ena = 1'b1;
            end
        end
        if (!bus.sample_strobe) check("period_timeout", n, -1);
    endtask

    function automatic int sd_groups(input logic [63:0] tk);
        int g = 0;
        for (int i = 0; i < 64; i += 4)
            if (int'(tk[i]) + int'(tk[i+1]) + int'(tk[i+2]) + int'(tk[i+3]) == 1) g++;
        return g;
    endfunction

    initial begin
        int n, ones, ones8;
        logic [63:0] tk;

        reset = 1'b1;
        bus.ena = 1'b1; bus.samples = '0; bus.mute = '0; bus.mode = 1'b0;
        bus8.ena = 1'b1; bus8.samples = '1; bus8.mute = '0; bus8.mode = 1'b0;
        model_reset();
        repeat (3) cycle();
        check("rst_level", bus.level, 0);
        check("rst_pwm", bus.pwm, 0);

        // All channels full scale, PWM mode.
        bus.samples = {CH{4'hF}};
        reset = 1'b0;
        run_to_strobe(3000, n);
        check("first_strobe_clocks", n, 2048);
        check("full_level", bus.level, 60);
        check("wide_strobe", bus8.sample_strobe, 1);
        check("wide_level", bus8.level, 2040);
        run_period(-1, -1, ones, ones8, n, tk);
        check("full_ones", ones, 60 * PD);
        check("strobe_interval", n, 2048);
        check("wide_ones", ones8, 2040);

        // Only muted channel carries signal.
        bus.samples = 16'h0900; bus.mute = 4'b0100;
        run_to_strobe(3000, n);
        check("mute_level", bus.level, 0);
        run_period(-1, -1, ones, ones8, n, tk);
        check("mute_ones", ones, 0);

        // Sigma-delta at level 16: one high tick in every four.
        bus.samples = 16'h001F; bus.mute = '0; bus.mode = 1'b1;
        run_to_strobe(3000, n);
        check("sd_level", bus.level, 16);
        run_period(-1, -1, ones, ones8, n, tk);
        check("sd_ones", ones, 16 * PD);
        check("sd_pattern", sd_groups(tk), 16);
        run_period(640, -1, ones, ones8, n, tk);
        check("sd_flip_ones", ones, 16 * PD);
        check("sd_flip_pattern", sd_groups(tk), 16);
        bus.samples = {CH{4'hF}};
        run_period(-1, -1, ones, ones8, n, tk);
        check("pwm16_pattern", tk, 64'h0000_0000_0000_FFFF);

        // ena low for 100 clocks mid-period.
        run_period(-1, 1000, ones, ones8, n, tk);
        check("ena_interval", n, 2048 + 100);

        // Reset at period counter 30, level 60 in PWM.
        repeat (970) cycle();
        check("pre_rst_level", bus.level, 60);
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst_level", bus.level, 0);
        check("midrst_pwm", bus.pwm, 0);
        check("midrst_strobe", bus.sample_strobe, 0);
        repeat (2) cycle();
        reset = 1'b0;
        run_to_strobe(3000, n);
        check("post_rst_strobe", n, 2048);

        // Random traffic: sample, mute, mode and ena changes at any time.
        for (int i = 0; i < 25000; i++) begin
            cycle();
            if (bus.sample_strobe || $urandom_range(0, 299) == 0) begin
                bus.samples = 16'($urandom);
                bus.mute    = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 1999) == 0) bus.mode = ~bus.mode;
            if (bus.ena) begin
                if ($urandom_range(0, 599) == 0) bus.ena = 1'b0;
            end else if ($urandom_range(0, 19) == 0) bus.ena = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
